button_reader: RTL and testbench

//  Input-side companion to the LED output driver: samples N_BTN raw push-button pads,

---
 rtl/button_pkg.sv | 25 ++
 rtl/btn_debounce.sv | 108 ++++++++++
 rtl/button_reader.sv | 123 ++++++++++++
 tb/tb_button_reader.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// button_pkg: event kind codes, per-button hold FSM encoding and counter sizing
// shared by button_reader and btn_debounce.
package button_pkg;

    // Event kinds carried on EVT_KIND
    localparam logic [1:0] EVT_PRESS   = 2'b00;
    localparam logic [1:0] EVT_RELEASE = 2'b01;
    localparam logic [1:0] EVT_LONG    = 2'b10;

    // Per-button hold FSM; LONG_HELD is only reachable with long-press enabled
    typedef enum logic [1:0] {
        ST_RELEASED  = 2'b00,
        ST_HELD      = 2'b01,
        ST_LONG_HELD = 2'b10
    } hold_state_t;

    // Number of bits needed to hold any value 0..max_val (never less than 1)
    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        while ((1 << w) <= max_val) w++;
        return w;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: one button's pad synchroniser, debounce counter and hold FSM.
// Produces the debounced level (1 = pressed) and single-cycle press/release/long pulses.
// Long-press detection is present only when BUTTON_READER_LONGPRESS_EN is defined.
module btn_debounce
    import button_pkg::*;
#(
    parameter int DEBOUNCE   = 10,
    parameter int LONG_PRESS = 100,
    parameter int ACTIVE_LOW = 1
) (
    input  logic        CLK,
    input  logic        NRST,
    input  logic        pad,
    output logic        level,
    output logic        press_pulse,
    output logic        release_pulse,
    output logic        long_pulse,
    output hold_state_t state_dbg
);
    localparam logic PAD_IDLE = (ACTIVE_LOW != 0);
    localparam int   DB_W     = cnt_width(DEBOUNCE - 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);

    // Reject configurations where the debounce window is empty or swallows the long press
    if (DEBOUNCE < 1 || LONG_PRESS <= DEBOUNCE) begin : g_bad_cfg
        $error("btn_debounce: requires DEBOUNCE >= 1 and LONG_PRESS > DEBOUNCE");
    end

    logic [1:0]      sync_q;
    logic            synced;
    logic [DB_W-1:0] db_cnt;
    hold_state_t     state_q, state_d;

    // Two-flop synchroniser, reset to the released pad level so reset never looks like a press
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) sync_q <= {2{PAD_IDLE}};
        else       sync_q <= {sync_q[0], pad};
    end

    // Normalise polarity: 1 = pressed regardless of pad wiring
    assign synced = sync_q[1] ^ PAD_IDLE;

    // Debounce: level flips only after DEBOUNCE consecutive samples disagreeing with it
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            db_cnt <= '0;
            level  <= 1'b0;
        end else if (synced == level) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            level  <= ~level;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

`ifdef BUTTON_READER_LONGPRESS_EN
    localparam int HOLD_W = cnt_width(LONG_PRESS);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS);
    logic [HOLD_W-1:0] hold_cnt;

    // Hold counter: runs only while HELD, saturates at LONG_PRESS, clears otherwise
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST)                   hold_cnt <= '0;
        else if (state_q != ST_HELD) hold_cnt <= '0;
        else if (hold_cnt != HOLD_LAST) hold_cnt <= hold_cnt + 1'b1;
    end
`endif

    // Hold FSM state register
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) state_q <= ST_RELEASED;
        else       state_q <= state_d;
    end

    // Hold FSM next state and event pulses; release takes precedence over long-press
    always_comb begin
        state_d       = state_q;
        press_pulse   = 1'b0;
        release_pulse = 1'b0;
        long_pulse    = 1'b0;
        case (state_q)
            ST_RELEASED: begin
                if (level) begin
                    press_pulse = 1'b1;
                    state_d     = ST_HELD;
                end
            end
            ST_HELD, ST_LONG_HELD: begin
                if (!level) begin
                    release_pulse = 1'b1;
                    state_d       = ST_RELEASED;
                end
`ifdef BUTTON_READER_LONGPRESS_EN
                else if (state_q == ST_HELD && hold_cnt == HOLD_LAST) begin
                    long_pulse = 1'b1;
                    state_d    = ST_LONG_HELD;
                end
`endif
            end
            default: state_d = ST_RELEASED;
        endcase
    end

    assign state_dbg = state_q;

endmodule

// File: rtl/button_reader.sv
// button_reader: N_BTN debounced push buttons feeding a single-entry event register.
// Optional long-press events are enabled by defining BUTTON_READER_LONGPRESS_EN.
// Handshake: an event transfers on a posedge CLK with EVT_VALID && EVT_READY; once EVT_VALID
// is raised it stays high with EVT_ID/EVT_KIND unchanged until that transfer happens.
module button_reader
    import button_pkg::*;
#(
    parameter int N_BTN      = 4,
    parameter int DEBOUNCE   = 10,
    parameter int LONG_PRESS = 100,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                   CLK,
    input  logic                   NRST,
    input  logic [N_BTN-1:0]       BTN_IN,
    output logic [N_BTN-1:0]       BTN_STATE,
    output logic                   EVT_VALID,
    input  logic                   EVT_READY,
    output logic [$clog2(N_BTN):0] EVT_ID,
    output logic [1:0]             EVT_KIND,
    output logic                   OVERRUN
);
    localparam int ID_W = $clog2(N_BTN) + 1;

    logic [N_BTN-1:0] press_p, release_p, long_p;
    logic [N_BTN-1:0] pend_press, pend_long, pend_rel;
    logic [N_BTN-1:0] sel_press, sel_long, sel_rel;
    logic [N_BTN-1:0] clr_press, clr_long, clr_rel;
    logic             sel_found, load, ovr_hit;
    logic [ID_W-1:0]  sel_id;
    logic [1:0]       sel_kind;
    hold_state_t      hold_state [N_BTN];

    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE   (DEBOUNCE),
            .LONG_PRESS (LONG_PRESS),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_btn (
            .CLK           (CLK),
            .NRST          (NRST),
            .pad           (BTN_IN[g]),
            .level         (BTN_STATE[g]),
            .press_pulse   (press_p[g]),
            .release_pulse (release_p[g]),
            .long_pulse    (long_p[g]),
            .state_dbg     (hold_state[g])
        );
    end

    // Event register may take a new event when empty or when its current one is being accepted
    assign load = !EVT_VALID || EVT_READY;

    // Arbiter: lowest-index button with anything pending; within it press > long > release
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        sel_kind  = EVT_PRESS;
        sel_press = '0;
        sel_long  = '0;
        sel_rel   = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (!sel_found && (pend_press[i] || pend_long[i] || pend_rel[i])) begin
                sel_found = 1'b1;
                sel_id    = ID_W'(i);
                if (pend_press[i]) begin
                    sel_kind     = EVT_PRESS;
                    sel_press[i] = 1'b1;
                end else if (pend_long[i]) begin
                    sel_kind    = EVT_LONG;
                    sel_long[i] = 1'b1;
                end else begin
                    sel_kind   = EVT_RELEASE;
                    sel_rel[i] = 1'b1;
                end
            end
        end
    end

    assign clr_press = load ? sel_press : '0;
    assign clr_long  = load ? sel_long  : '0;
    assign clr_rel   = load ? sel_rel   : '0;

    // A pulse lands on a bit that stays pending (not leaving this cycle): that event is lost
    assign ovr_hit = |((press_p   & pend_press & ~clr_press) |
                       (long_p    & pend_long  & ~clr_long)  |
                       (release_p & pend_rel   & ~clr_rel));

    // Pending bits: a new pulse wins over a same-cycle load-clear of the same bit
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            pend_press <= '0;
            pend_long  <= '0;
            pend_rel   <= '0;
        end else begin
            pend_press <= (pend_press & ~clr_press) | press_p;
            pend_long  <= (pend_long  & ~clr_long)  | long_p;
            pend_rel   <= (pend_rel   & ~clr_rel)   | release_p;
        end
    end

    // Event register: reload only when free, so a presented event is never withdrawn
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            EVT_VALID <= 1'b0;
            EVT_ID    <= '0;
            EVT_KIND  <= EVT_PRESS;
        end else if (load) begin
            EVT_VALID <= sel_found;
            if (sel_found) begin
                EVT_ID   <= sel_id;
                EVT_KIND <= sel_kind;
            end
        end
    end

    // Sticky overrun flag, cleared only by reset
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST)        OVERRUN <= 1'b0;
        else if (ovr_hit) OVERRUN <= 1'b1;
    end

endmodule

// File: tb/tb_button_reader.sv
// tb_button_reader: directed scenarios plus a randomized run against a behavioural model.
module tb_button_reader;
  import button_pkg::*;

  localparam int N_BTN      = 4;
  localparam int DEBOUNCE   = 10;
  localparam int LONG_PRESS = 100;
  localparam int ID_W       = $clog2(N_BTN) + 1;
  localparam int LAT        = 2 + DEBOUNCE;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      kind;
    logic [31:0]     cyc;
  } ev_t;

  // clock / reset / DUT
  logic              CLK = 1'b0;
  logic              NRST = 1'b0;
  logic [N_BTN-1:0]  pressed = '0;
  logic [N_BTN-1:0]  BTN_IN;
  logic [N_BTN-1:0]  BTN_STATE;
  logic              EVT_VALID;
  logic              EVT_READY = 1'b0;
  logic [ID_W-1:0]   EVT_ID;
  logic [1:0]        EVT_KIND;
  logic              OVERRUN;

  int checks = 0;
  int failures = 0;
  logic [31:0] cyc_cnt = '0;
  ev_t act_q[$];
  logic [1:0] exp_q [N_BTN][$];

  always #5 CLK = ~CLK;
  assign BTN_IN = ~pressed;  // active-low pads

  button_reader #(
    .N_BTN(N_BTN), .DEBOUNCE(DEBOUNCE), .LONG_PRESS(LONG_PRESS), .ACTIVE_LOW(1)
  ) dut (
    .CLK(CLK), .NRST(NRST), .BTN_IN(BTN_IN), .BTN_STATE(BTN_STATE),
    .EVT_VALID(EVT_VALID), .EVT_READY(EVT_READY), .EVT_ID(EVT_ID),
    .EVT_KIND(EVT_KIND), .OVERRUN(OVERRUN)
  );

  always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

  // capture every handshake that will complete at the coming posedge
  always @(negedge CLK) begin
    if (NRST && EVT_VALID && EVT_READY) act_q.push_back({EVT_ID, EVT_KIND, cyc_cnt});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic test_reset();
    NRST = 1'b0; EVT_READY = 1'b0; pressed = '0;
    step(3);
    checks++; if (BTN_STATE !== '0) begin failures++; $display("FAIL reset_btn_state: got %0h expected 0", BTN_STATE); end
    checks++; if (EVT_VALID !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b expected 0", EVT_VALID); end
    checks++; if (EVT_ID !== '0) begin failures++; $display("FAIL reset_id: got %0d expected 0", EVT_ID); end
    checks++; if (EVT_KIND !== 2'b00) begin failures++; $display("FAIL reset_kind: got %0b expected 00", EVT_KIND); end
    checks++; if (OVERRUN !== 1'b0) begin failures++; $display("FAIL reset_overrun: got %0b expected 0", OVERRUN); end
    NRST = 1'b1;
    step(20);
    checks++; if (EVT_VALID !== 1'b0 || BTN_STATE !== '0) begin
      failures++; $display("FAIL idle_after_reset: got valid=%0b state=%0h expected 0/0", EVT_VALID, BTN_STATE);
    end
  endtask

  task automatic test_clean_press();
    int lat;
    ev_t e;
    EVT_READY = 1'b1; act_q.delete();
    pressed[0] = 1'b1;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (BTN_STATE[0]) begin lat = k; break; end
    end
    checks++; if (lat != LAT) begin failures++; $display("FAIL press_latency: got %0d expected %0d", lat, LAT); end
    step(50 - LAT);
    pressed[0] = 1'b0;
    step(30);
    checks++; if (act_q.size() != 2) begin
      failures++; $display("FAIL clean_event_count: got %0d expected 2", act_q.size());
    end else begin
      e = act_q[0];
      checks++; if (e.id !== ID_W'(0) || e.kind !== EVT_PRESS) begin
        failures++; $display("FAIL clean_first: got id=%0d kind=%0b expected id=0 kind=00", e.id, e.kind);
      end
      e = act_q[1];
      checks++; if (e.id !== ID_W'(0) || e.kind !== EVT_RELEASE) begin
        failures++; $display("FAIL clean_second: got id=%0d kind=%0b expected id=0 kind=01", e.id, e.kind);
      end
    end
    act_q.delete();
  endtask

  task automatic test_bounce();
    logic moved;
    moved = 1'b0;
    act_q.delete();
    for (int p = 0; p < 4; p++) begin
      pressed[1] = 1'b1;
      repeat (5) begin @(negedge CLK); if (BTN_STATE !== '0) moved = 1'b1; @(posedge CLK); #1; end
      pressed[1] = 1'b0;
      repeat (5) begin @(negedge CLK); if (BTN_STATE !== '0) moved = 1'b1; @(posedge CLK); #1; end
    end
    repeat (20) begin @(negedge CLK); if (BTN_STATE !== '0) moved = 1'b1; @(posedge CLK); #1; end
    checks++; if (moved !== 1'b0) begin failures++; $display("FAIL bounce_state: got change=%0b expected 0", moved); end
    checks++; if (act_q.size() != 0) begin failures++; $display("FAIL bounce_events: got %0d expected 0", act_q.size()); end
    checks++; if (OVERRUN !== 1'b0) begin failures++; $display("FAIL bounce_overrun: got %0b expected 0", OVERRUN); end
  endtask

  task automatic test_simultaneous();
    ev_t a, b;
    act_q.delete(); EVT_READY = 1'b1;
    pressed[3] = 1'b1; pressed[1] = 1'b1;
    step(25);
    checks++; if (act_q.size() != 2) begin
      failures++; $display("FAIL simul_count: got %0d expected 2", act_q.size());
    end else begin
      a = act_q[0]; b = act_q[1];
      checks++; if (a.id !== ID_W'(1) || a.kind !== EVT_PRESS) begin
        failures++; $display("FAIL simul_first: got id=%0d kind=%0b expected id=1 kind=00", a.id, a.kind);
      end
      checks++; if (b.id !== ID_W'(3) || b.kind !== EVT_PRESS) begin
        failures++; $display("FAIL simul_second: got id=%0d kind=%0b expected id=3 kind=00", b.id, b.kind);
      end
      checks++; if (b.cyc != a.cyc + 1) begin
        failures++; $display("FAIL simul_b2b: got gap=%0d expected 1", b.cyc - a.cyc);
      end
    end
    pressed[3] = 1'b0; pressed[1] = 1'b0;
    step(30);
    act_q.delete();
  endtask

  task automatic test_backpressure();
    logic seen, unstable;
    logic [ID_W-1:0] cap_id;
    logic [1:0] cap_kind;
    ev_t e;
    seen = 1'b0; unstable = 1'b0; cap_id = '0; cap_kind = 2'b11;
    EVT_READY = 1'b0; act_q.delete();
    for (int t = 0; t < 90; t++) begin
      pressed[2] = (t < 20) || (t >= 40 && t < 60);
      @(negedge CLK);
      if (seen && (!EVT_VALID || EVT_ID !== cap_id || EVT_KIND !== cap_kind)) unstable = 1'b1;
      if (!seen && EVT_VALID) begin seen = 1'b1; cap_id = EVT_ID; cap_kind = EVT_KIND; end
      @(posedge CLK); #1;
    end
    checks++; if (seen !== 1'b1 || cap_id !== ID_W'(2) || cap_kind !== EVT_PRESS) begin
      failures++; $display("FAIL bp_held_event: got seen=%0b id=%0d kind=%0b expected 1/2/00", seen, cap_id, cap_kind);
    end
    checks++; if (unstable !== 1'b0) begin failures++; $display("FAIL bp_stable: got unstable=%0b expected 0", unstable); end
    checks++; if (OVERRUN !== 1'b1) begin failures++; $display("FAIL bp_overrun: got %0b expected 1", OVERRUN); end
    EVT_READY = 1'b1;
    step(8);
    checks++; if (act_q.size() != 3) begin
      failures++; $display("FAIL bp_drain_count: got %0d expected 3", act_q.size());
    end else begin
      e = act_q[0];
      checks++; if (e.id !== ID_W'(2) || e.kind !== EVT_PRESS) begin
        failures++; $display("FAIL bp_drain0: got id=%0d kind=%0b expected id=2 kind=00", e.id, e.kind);
      end
      e = act_q[1];
      checks++; if (e.id !== ID_W'(2) || e.kind !== EVT_PRESS) begin
        failures++; $display("FAIL bp_drain1: got id=%0d kind=%0b expected id=2 kind=00", e.id, e.kind);
      end
      e = act_q[2];
      checks++; if (e.id !== ID_W'(2) || e.kind !== EVT_RELEASE) begin
        failures++; $display("FAIL bp_drain2: got id=%0d kind=%0b expected id=2 kind=01", e.id, e.kind);
      end
    end
    checks++; if (EVT_VALID !== 1'b0) begin failures++; $display("FAIL bp_empty: got valid=%0b expected 0", EVT_VALID); end
    act_q.delete();
  endtask

  task automatic test_long_press();
    ev_t e;
    act_q.delete(); EVT_READY = 1'b1;
    pressed[0] = 1'b1;
    step(150);
    pressed[0] = 1'b0;
    step(30);
`ifdef BUTTON_READER_LONGPRESS_EN
    checks++; if (act_q.size() != 3) begin
      failures++; $display("FAIL long_count: got %0d expected 3", act_q.size());
    end else begin
      e = act_q[1];
      checks++; if (act_q[0].kind !== EVT_PRESS || e.kind !== EVT_LONG || act_q[2].kind !== EVT_RELEASE) begin
        failures++; $display("FAIL long_kinds: got %0b,%0b,%0b expected 00,10,01", act_q[0].kind, e.kind, act_q[2].kind);
      end
      checks++; if (e.cyc - act_q[0].cyc < LONG_PRESS - 5 || e.cyc - act_q[0].cyc > LONG_PRESS + 5) begin
        failures++; $display("FAIL long_delay: got %0d expected about %0d", e.cyc - act_q[0].cyc, LONG_PRESS);
      end
    end
`else
    checks++; if (act_q.size() != 2) begin
      failures++; $display("FAIL long_count: got %0d expected 2", act_q.size());
    end else begin
      e = act_q[1];
      checks++; if (act_q[0].kind !== EVT_PRESS || e.kind !== EVT_RELEASE || act_q[0].id !== ID_W'(0) || e.id !== ID_W'(0)) begin
        failures++; $display("FAIL long_kinds: got %0b,%0b expected 00,01", act_q[0].kind, e.kind);
      end
    end
`endif
    act_q.delete();
  endtask

  task automatic test_reset_mid_press();
    logic was_valid;
    int lat;
    ev_t e;
    EVT_READY = 1'b0; act_q.delete(); was_valid = 1'b0;
    pressed[0] = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (EVT_VALID) begin was_valid = 1'b1; break; end
    end
    checks++; if (was_valid !== 1'b1) begin failures++; $display("FAIL mid_pre_valid: got %0b expected 1", was_valid); end
    @(posedge CLK); #1;
    NRST = 1'b0;
    #1;
    checks++; if (BTN_STATE !== '0 || EVT_VALID !== 1'b0 || OVERRUN !== 1'b0 || EVT_KIND !== 2'b00 || EVT_ID !== '0) begin
      failures++; $display("FAIL mid_async_clear: got state=%0h valid=%0b ovr=%0b kind=%0b id=%0d expected all 0",
                           BTN_STATE, EVT_VALID, OVERRUN, EVT_KIND, EVT_ID);
    end
    step(3);
    NRST = 1'b1; EVT_READY = 1'b1; act_q.delete();
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (BTN_STATE[0]) begin lat = k; break; end
    end
    checks++; if (lat != LAT) begin failures++; $display("FAIL mid_repress_latency: got %0d expected %0d", lat, LAT); end
    step(30);
    checks++; if (act_q.size() != 1) begin
      failures++; $display("FAIL mid_event_count: got %0d expected 1", act_q.size());
    end else begin
      e = act_q[0];
      checks++; if (e.id !== ID_W'(0) || e.kind !== EVT_PRESS) begin
        failures++; $display("FAIL mid_event: got id=%0d kind=%0b expected id=0 kind=00", e.id, e.kind);
      end
    end
    pressed[0] = 1'b0;
    step(30);
    act_q.delete();
  endtask

  // Reference model: a button's debounced level flips once the synced pad (pad seen 3 cycles
  // earlier) has disagreed with it for DEBOUNCE consecutive cycles; each flip yields a
  // press/release, and a level held for LONG_PRESS+2 cycles yields one long-press.
  task automatic test_random();
    int unsigned seg_left [N_BTN];
    int run [N_BTN];
    int held [N_BTN];
    logic [N_BTN-1:0] hist[$];
    logic [N_BTN-1:0] synced, mlvl;
    int r;
    ev_t e;
    act_q.delete();
    for (int b = 0; b < N_BTN; b++) begin
      exp_q[b].delete(); run[b] = 0; held[b] = 0; seg_left[b] = $urandom_range(5, 40);
    end
    for (int k = 0; k < 3; k++) hist.push_back('0);
    mlvl = '0;
    pressed = '0;
    for (int c = 0; c < 3300; c++) begin
      @(posedge CLK); #1;
      if (c < 3000) begin
        for (int b = 0; b < N_BTN; b++) begin
          if (seg_left[b] == 0) begin
            pressed[b] = ~pressed[b];
            r = $urandom_range(0, 19);
            if (r < 6)       seg_left[b] = $urandom_range(1, DEBOUNCE - 1);
            else if (r < 18) seg_left[b] = $urandom_range(DEBOUNCE + 3, 50);
            else             seg_left[b] = $urandom_range(LONG_PRESS + 5, LONG_PRESS + 40);
          end else begin
            seg_left[b]--;
          end
        end
        EVT_READY = ($urandom_range(0, 7) != 0);
      end else begin
        pressed = '0;
        EVT_READY = 1'b1;
      end
      hist.push_back(pressed);
      synced = hist.pop_front();
      for (int b = 0; b < N_BTN; b++) begin
        if (synced[b] != mlvl[b]) begin
          run[b]++;
          if (run[b] == DEBOUNCE) begin
            mlvl[b] = ~mlvl[b];
            run[b] = 0;
            held[b] = 0;
            exp_q[b].push_back(mlvl[b] ? EVT_PRESS : EVT_RELEASE);
          end
        end else begin
          run[b] = 0;
        end
        if (mlvl[b]) begin
          held[b]++;
`ifdef BUTTON_READER_LONGPRESS_EN
          if (held[b] == LONG_PRESS + 2) exp_q[b].push_back(EVT_LONG);
`endif
        end
      end
      @(negedge CLK);
      checks++; if (BTN_STATE !== mlvl) begin
        failures++; $display("FAIL rand_state cycle %0d: got %0h expected %0h", c, BTN_STATE, mlvl);
      end
      while (act_q.size() > 0) begin
        e = act_q.pop_front();
        checks++;
        if (e.id >= N_BTN) begin
          failures++; $display("FAIL rand_id: got %0d expected below %0d", e.id, N_BTN);
        end else if (exp_q[e.id].size() == 0) begin
          failures++; $display("FAIL rand_unexpected: got id=%0d kind=%0b expected none", e.id, e.kind);
        end else begin
          logic [1:0] want;
          want = exp_q[e.id].pop_front();
          if (e.kind !== want) begin
            failures++; $display("FAIL rand_kind id=%0d: got %0b expected %0b", e.id, e.kind, want);
          end
        end
      end
    end
    for (int b = 0; b < N_BTN; b++) begin
      checks++; if (exp_q[b].size() != 0) begin
        failures++; $display("FAIL rand_missing btn %0d: got %0d left expected 0", b, exp_q[b].size());
      end
    end
    checks++; if (OVERRUN !== 1'b0) begin failures++; $display("FAIL rand_overrun: got %0b expected 0", OVERRUN); end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_backpressure();
    test_long_press();
    test_reset_mid_press();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
